// File: rtl/pet_state_engine.sv
// pet_state_engine: four saturating need levels, a decay prescaler and a registered mood code.
// Optional build macro PET_DEATH_EN: three consecutive zero-health ticks latch the terminal DEAD mood.
module pet_state_engine #(
    parameter int CLK_HZ   = 50000000,
    parameter int TICK_SEC = 10,
    parameter int TEST_DIV = 10,
    parameter int MAX_LVL  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frio,
    input  logic       calor,
    input  logic       regluz,
    input  logic       cerca,
    input  logic       regjugar,
    input  logic       regalimentar,
    input  logic       regcurar,
    input  logic       regtest,
    output logic [2:0] hunger,
    output logic [2:0] energy,
    output logic [2:0] happy,
    output logic [2:0] health,
    output logic [2:0] state,
    output logic       test_mode,
    output logic       tick
);

    localparam int              PERIOD   = CLK_HZ * TICK_SEC;
    localparam int              CW       = $clog2(PERIOD);
    localparam logic [CW-1:0]   LIM_NORM = CW'(PERIOD - 1);
    localparam logic [CW-1:0]   LIM_TEST = CW'(PERIOD / TEST_DIV - 1);
    localparam logic [3:0]      MAX4     = 4'(MAX_LVL);
    localparam logic [2:0]      HIGH3    = 3'(MAX_LVL - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HAPPY  = 3'd1,
        S_SAD    = 3'd2,
        S_HUNGRY = 3'd3,
        S_TIRED  = 3'd4,
        S_SICK   = 3'd5,
        S_SLEEP  = 3'd6,
        S_DEAD   = 3'd7
    } mood_t;

    mood_t         state_q;
    mood_t         state_d;
    mood_t         mood;

    logic          jugar_q, alim_q, curar_q, test_q;
    logic          jugar_rise, alim_rise, curar_rise, test_rise;
    logic          dead;
    logic          test_toggle, feed_go, play_go, cure_go;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic          wrap, tick_now, decay;
    logic [3:0]    h4, e4, p4, l4;

    function automatic logic [3:0] dec4(input logic [3:0] v);
        return (v == 4'd0) ? 4'd0 : v - 4'd1;
    endfunction

    function automatic logic [3:0] sat4(input logic [3:0] v);
        return (v > MAX4) ? MAX4 : v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            jugar_q <= 1'b0;
            alim_q  <= 1'b0;
            curar_q <= 1'b0;
            test_q  <= 1'b0;
        end else begin
            jugar_q <= regjugar;
            alim_q  <= regalimentar;
            curar_q <= regcurar;
            test_q  <= regtest;
        end
    end

    assign jugar_rise = regjugar & ~jugar_q;
    assign alim_rise  = regalimentar & ~alim_q;
    assign curar_rise = regcurar & ~curar_q;
    assign test_rise  = regtest & ~test_q;

    // Cure cancels feed/play so the combined button chord only heals.
    assign test_toggle = test_rise & ~dead;
    assign feed_go     = alim_rise & ~regcurar & (state_q != S_SLEEP) & ~dead;
    assign play_go     = jugar_rise & ~regcurar & (state_q != S_SLEEP) & ~dead;
    assign cure_go     = curar_rise & ~dead;

    assign limit    = test_mode ? LIM_TEST : LIM_NORM;
    assign wrap     = (cnt >= limit);
    assign tick_now = wrap & ~test_toggle;
    assign decay    = tick_now & ~dead;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            tick      <= 1'b0;
            test_mode <= 1'b0;
        end else if (test_toggle) begin
            cnt       <= '0;
            tick      <= 1'b0;
            test_mode <= ~test_mode;
        end else if (wrap) begin
            cnt       <= '0;
            tick      <= 1'b1;
        end else begin
            cnt       <= cnt + 1'b1;
            tick      <= 1'b0;
        end
    end

    // Decay first with a floor at 0, then actions with the ceiling; 4 bits keep +2 from wrapping.
    always_comb begin
        h4 = {1'b0, hunger};
        e4 = {1'b0, energy};
        p4 = {1'b0, happy};
        l4 = {1'b0, health};
        if (decay) begin
            h4 = dec4(h4);
            e4 = regluz ? dec4(e4) : sat4(e4 + 4'd1);
            if (!cerca) p4 = dec4(p4);
            if (frio || calor || (hunger == 3'd0)) l4 = dec4(l4);
        end
        if (feed_go) h4 = sat4(h4 + 4'd2);
        if (play_go) begin
            p4 = sat4(p4 + 4'd2);
            e4 = dec4(e4);
        end
        if (cure_go) l4 = sat4(l4 + 4'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hunger <= 3'(MAX_LVL);
            energy <= 3'(MAX_LVL);
            happy  <= 3'(MAX_LVL);
            health <= 3'(MAX_LVL);
        end else begin
            hunger <= h4[2:0];
            energy <= e4[2:0];
            happy  <= p4[2:0];
            health <= l4[2:0];
        end
    end

    always_comb begin
        mood = S_IDLE;
        if (!regluz)                mood = S_SLEEP;
        else if (health <= 3'd1)    mood = S_SICK;
        else if (hunger <= 3'd1)    mood = S_HUNGRY;
        else if (energy <= 3'd1)    mood = S_TIRED;
        else if (happy <= 3'd1)     mood = S_SAD;
        else if (hunger >= HIGH3 && energy >= HIGH3 && happy >= HIGH3 && health >= HIGH3)
            mood = S_HAPPY;
    end

`ifdef PET_DEATH_EN
    logic [1:0] zero_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_cnt <= 2'd0;
        end else if (tick_now) begin
            if (health != 3'd0)         zero_cnt <= 2'd0;
            else if (zero_cnt != 2'd3)  zero_cnt <= zero_cnt + 2'd1;
        end
    end

    assign dead = (state_q == S_DEAD);

    always_comb begin
        state_d = mood;
        if (dead || (tick_now && (health == 3'd0) && (zero_cnt == 2'd2)))
            state_d = S_DEAD;
    end
`else
    assign dead = 1'b0;

    always_comb begin
        state_d = mood;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: tb/tb_pet_state_engine.sv
// tb_pet_state_engine: directed vector table, multi-cycle corner sequences and random stimulus
// checked against a cycle-level behavioural model of the pet rules.
module tb_pet_state_engine;

    localparam int CLK_HZ   = 10;
    localparam int TICK_SEC = 1;
    localparam int TEST_DIV = 5;
    localparam int MAX      = 5;
    localparam int PER_N    = CLK_HZ * TICK_SEC;
    localparam int PER_T    = CLK_HZ * TICK_SEC / TEST_DIV;

    // input vector bits: {frio, calor, regluz, cerca, regjugar, regalimentar, regcurar, regtest}
    localparam logic [7:0] FR = 8'h80, CA = 8'h40, L = 8'h20, C = 8'h10;
    localparam logic [7:0] J = 8'h08, A = 8'h04, R = 8'h02, T = 8'h01;

    logic clk, rst;
    logic frio, calor, regluz, cerca, regjugar, regalimentar, regcurar, regtest;
    logic [2:0] hunger, energy, happy, health, state;
    logic test_mode, tick;

    pet_state_engine #(
        .CLK_HZ(CLK_HZ), .TICK_SEC(TICK_SEC), .TEST_DIV(TEST_DIV), .MAX_LVL(MAX)
    ) dut (
        .clk(clk), .rst(rst), .frio(frio), .calor(calor), .regluz(regluz), .cerca(cerca),
        .regjugar(regjugar), .regalimentar(regalimentar), .regcurar(regcurar), .regtest(regtest),
        .hunger(hunger), .energy(energy), .happy(happy), .health(health),
        .state(state), .test_mode(test_mode), .tick(tick)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // ---------------- behavioural model ----------------
    int m_h, m_e, m_p, m_hl, m_st, m_phase, m_zero;
    bit m_tm, m_tk, m_dead, m_pj, m_pa, m_pc, m_pt;
    logic [16:0] exp_q[$];

    function automatic int lo(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    function automatic int hi(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    function automatic int mood_of(input bit lz, input int h, input int e, input int p, input int hl);
        if (!lz)     return 6;
        if (hl <= 1) return 5;
        if (h <= 1)  return 3;
        if (e <= 1)  return 4;
        if (p <= 1)  return 2;
        if (h >= MAX - 1 && e >= MAX - 1 && p >= MAX - 1 && hl >= MAX - 1) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_h = MAX; m_e = MAX; m_p = MAX; m_hl = MAX; m_st = 0;
            m_tm = 0; m_tk = 0; m_phase = 0; m_zero = 0; m_dead = 0;
            m_pj = 0; m_pa = 0; m_pc = 0; m_pt = 0;
        end else begin
            automatic bit was_dead = m_dead;
            automatic int old_st = m_st;
            automatic int mood_v = mood_of(regluz, m_h, m_e, m_p, m_hl);
            automatic bit blocked = regcurar || (old_st == 6) || was_dead;
            automatic bit feed = regalimentar && !m_pa && !blocked;
            automatic bit play = regjugar && !m_pj && !blocked;
            automatic bit cure = regcurar && !m_pc && !was_dead;
            automatic bit tog  = regtest && !m_pt && !was_dead;
            automatic int nh = m_h, ne = m_e, np = m_p, nhl = m_hl;
            if (tog) begin
                m_tm = !m_tm; m_phase = 0; m_tk = 0;
            end else begin
                m_phase++;
                m_tk = (m_phase == (m_tm ? PER_T : PER_N));
                if (m_tk) m_phase = 0;
            end
`ifdef PET_DEATH_EN
            if (m_tk) begin
                if (m_hl == 0) m_zero++; else m_zero = 0;
                if (m_zero >= 3) m_dead = 1;
            end
`endif
            if (!was_dead) begin
                if (m_tk) begin
                    nh = lo(m_h - 1);
                    ne = regluz ? lo(m_e - 1) : hi(m_e + 1);
                    if (!cerca) np = lo(m_p - 1);
                    if (frio || calor || m_h == 0) nhl = lo(m_hl - 1);
                end
                if (feed) nh = hi(nh + 2);
                if (play) begin np = hi(np + 2); ne = lo(ne - 1); end
                if (cure) nhl = hi(nhl + 2);
            end
            m_h = nh; m_e = ne; m_p = np; m_hl = nhl;
            m_st = m_dead ? 7 : mood_v;
            m_pj = regjugar; m_pa = regalimentar; m_pc = regcurar; m_pt = regtest;
        end
        if (chk_en)
            exp_q.push_back({3'(m_h), 3'(m_e), 3'(m_p), 3'(m_hl), 3'(m_st), m_tm, m_tk});
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en && exp_q.size() > 0) begin
            automatic logic [16:0] exp_v = exp_q.pop_front();
            automatic logic [16:0] got_v = {hunger, energy, happy, health, state, test_mode, tick};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL model t=%0t got %h expected %h", $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [7:0] v);
        {frio, calor, regluz, cerca, regjugar, regalimentar, regcurar, regtest} = v;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input logic [7:0] v);
        rst = 1'b1;
        drive(v);
        run(2);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rs;
        int         n;
        logic [7:0] in;
        logic [2:0] h, e, p, hl, st;
        logic       tm, tk;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst = 1'b1;
        drive(8'h00);
        reset_dut(L);
        chk_en = 1'b1;

        // decay in daylight, mood thresholds
        vecs.push_back('{1'b1,  9, L,     3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L,     3'd4, 3'd4, 3'd4, 3'd5, 3'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0,  1, L,     3'd4, 3'd4, 3'd4, 3'd5, 3'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 19, L,     3'd2, 3'd2, 3'd2, 3'd5, 3'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0,  1, L,     3'd2, 3'd2, 3'd2, 3'd5, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  9, L,     3'd1, 3'd1, 3'd1, 3'd5, 3'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b0,  1, L,     3'd1, 3'd1, 3'd1, 3'd5, 3'd3, 1'b0, 1'b0});
        // darkness: sleep, energy recovers, feed ignored
        vecs.push_back('{1'b1,  1, 8'h00, 3'd5, 3'd5, 3'd5, 3'd5, 3'd6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 19, 8'h00, 3'd3, 3'd5, 3'd3, 3'd5, 3'd6, 1'b0, 1'b1});
        vecs.push_back('{1'b0,  1, A,     3'd3, 3'd5, 3'd3, 3'd5, 3'd6, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, 8'h00, 3'd3, 3'd5, 3'd3, 3'd5, 3'd6, 1'b0, 1'b0});
        // test mode toggles and prescaler restart
        vecs.push_back('{1'b1,  3, L,     3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L | T, 3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0,  1, L,     3'd5, 3'd5, 3'd5, 3'd5, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b0,  1, L,     3'd4, 3'd4, 3'd4, 3'd5, 3'd1, 1'b1, 1'b1});
        vecs.push_back('{1'b0,  2, L,     3'd3, 3'd3, 3'd3, 3'd5, 3'd1, 1'b1, 1'b1});
        vecs.push_back('{1'b0,  1, L,     3'd3, 3'd3, 3'd3, 3'd5, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b0,  1, L | T, 3'd3, 3'd3, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  9, L,     3'd3, 3'd3, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L,     3'd2, 3'd2, 3'd2, 3'd5, 3'd0, 1'b0, 1'b1});
        // starvation, feed on a tick cycle, feed saturation
        vecs.push_back('{1'b1, 59, L | C,     3'd0, 3'd0, 3'd5, 3'd5, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L | C | A, 3'd2, 3'd0, 3'd5, 3'd4, 3'd3, 1'b0, 1'b1});
        vecs.push_back('{1'b0,  1, L | C,     3'd2, 3'd0, 3'd5, 3'd4, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L | C | A, 3'd4, 3'd0, 3'd5, 3'd4, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L | C,     3'd4, 3'd0, 3'd5, 3'd4, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L | C | A, 3'd5, 3'd0, 3'd5, 3'd4, 3'd4, 1'b0, 1'b0});
        // cold lowers health; button chord only cures; lone play
        vecs.push_back('{1'b1, 20, L | FR,        3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 1'b0, 1'b1});
        vecs.push_back('{1'b0,  1, L | J | A | R, 3'd3, 3'd3, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L,             3'd3, 3'd3, 3'd3, 3'd5, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L | J,         3'd3, 3'd2, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b0,  1, L,             3'd3, 3'd2, 3'd5, 3'd5, 3'd0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            if (vecs[i].rs) reset_dut(vecs[i].in);
            else            drive(vecs[i].in);
            run(vecs[i].n);
            chk($sformatf("vec%0d.hunger", i), hunger, vecs[i].h);
            chk($sformatf("vec%0d.energy", i), energy, vecs[i].e);
            chk($sformatf("vec%0d.happy", i), happy, vecs[i].p);
            chk($sformatf("vec%0d.health", i), health, vecs[i].hl);
            chk($sformatf("vec%0d.state", i), state, vecs[i].st);
            chk($sformatf("vec%0d.test_mode", i), {2'b00, test_mode}, {2'b00, vecs[i].tm});
            chk($sformatf("vec%0d.tick", i), {2'b00, tick}, {2'b00, vecs[i].tk});
        end

        // heat plus starvation down to zero health, then three more ticks
        reset_dut(L | CA);
        run(80);
        chk("sweep.health", health, 3'd0);
        chk("sweep.tick", {2'b00, tick}, 3'd1);
`ifdef PET_DEATH_EN
        chk("sweep.state", state, 3'd7);
`else
        chk("sweep.state", state, 3'd5);
`endif
        drive(L | R);
        run(1);
`ifdef PET_DEATH_EN
        chk("sweep.cure_health", health, 3'd0);
        chk("sweep.cure_state", state, 3'd7);
`else
        chk("sweep.cure_health", health, 3'd2);
        chk("sweep.cure_state", state, 3'd5);
`endif
        drive(L);
        run(1);
`ifdef PET_DEATH_EN
        chk("sweep.after_state", state, 3'd7);
`else
        chk("sweep.after_state", state, 3'd3);
`endif
        rst = 1'b1;
        run(2);
        chk("sweep.rst_hunger", hunger, 3'd5);
        chk("sweep.rst_energy", energy, 3'd5);
        chk("sweep.rst_happy", happy, 3'd5);
        chk("sweep.rst_health", health, 3'd5);
        chk("sweep.rst_state", state, 3'd0);
        chk("sweep.rst_tick", {2'b00, tick}, 3'd0);
        rst = 1'b0;

        // random stimulus against the model
        begin
            logic [7:0] v;
            v = L;
            for (int i = 0; i < 3000; i++) begin
                v[7] = ($urandom_range(0, 5) == 0);
                v[6] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 49) == 0) v[5] = ~v[5];
                v[4] = ($urandom_range(0, 1) == 0);
                v[3] = ($urandom_range(0, 3) == 0);
                v[2] = ($urandom_range(0, 3) == 0);
                v[1] = ($urandom_range(0, 5) == 0);
                v[0] = ($urandom_range(0, 19) == 0);
                rst = ($urandom_range(0, 399) == 0);
                drive(v);
                run(1);
            end
            rst = 1'b0;
            run(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
